// File: rtl/jam_pkg.sv
// Shared constants and types for the JAM cost-table responder.
package jam_pkg;

  localparam int N_WORKER    = 8;
  localparam int TABLE_DEPTH = N_WORKER * N_WORKER;
  localparam int IDX_W       = 6;
  localparam int COST_W      = 7;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Row-major table address: worker index in the upper bits, job in the lower.
  function automatic logic [IDX_W-1:0] table_addr(input logic [2:0] w, input logic [2:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/jam_cost_table.sv
// 64-entry cost storage: one synchronous write port, one combinational read port.
module jam_cost_table
  import jam_pkg::*;
#(
  parameter int WIDTH = COST_W
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [TABLE_DEPTH];

  // Write port. NOTE: the array has no reset on purpose; it is always fully
  // reloaded before it is read, and a reset would turn it into 448 resettable flops.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Zero-latency read so the requester can sample on either clock edge.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// JAM cost-table responder: loads the 8x8 cost table over a valid/ready
// stream, serves Cost = table[W][J] combinationally, then checks the
// requester's MinCost/MatchCount against expected values under a watchdog.
// Optional build macro: JAM_READ_COVERAGE_EN (adds a read-coverage mask that
// must be full for pass; cov_full reports it, otherwise cov_full is tied to 1).
module jam_cost_server #(
  parameter int COST_W  = jam_pkg::COST_W,
  parameter int RES_W   = 10,
  parameter int CNT_W   = 17,
  parameter int TIMEOUT = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [COST_W-1:0] ld_data,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic [RES_W-1:0]  MinCost,
  input  logic [3:0]        MatchCount,
  input  logic              Valid,
  input  logic [RES_W-1:0]  exp_min_cost,
  input  logic [3:0]        exp_match_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles,
  output logic              cov_full
);
  import jam_pkg::*;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(TABLE_DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ld_ready_q, ld_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  logic              ld_fire;
  logic              result_ok;
  logic              cov_ok;
  logic [CNT_W-1:0]  cycles_inc;
  logic [COST_W-1:0] tbl_rd;

  assign ld_fire    = (state_q == LOAD) && ld_valid && ld_ready_q;
  assign result_ok  = (MinCost == exp_min_cost) && (MatchCount == exp_match_count);
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

  jam_cost_table #(
    .WIDTH (COST_W)
  ) u_table (
    .CLK   (CLK),
    .we    (ld_fire),
    .waddr (idx_q),
    .wdata (ld_data),
    .raddr (table_addr(W, J)),
    .rdata (tbl_rd)
  );

  // Outside SERVE the table may hold uninitialised data, so Cost is forced low.
  assign Cost = (state_q == SERVE) ? tbl_rd : '0;

`ifdef JAM_READ_COVERAGE_EN
  logic [TABLE_DEPTH-1:0] mask_q, mask_d, mask_now;

  // Mask including the address being read this cycle, so a capture cycle counts.
  always_comb begin
    mask_now = mask_q | (TABLE_DEPTH'(1) << table_addr(W, J));
    mask_d   = mask_q;
    if (state_q == SERVE) begin
      mask_d = mask_now;
    end else if (state_q == LOAD) begin
      mask_d = '0;
    end
  end

  // Coverage mask register; cleared in reset and throughout LOAD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign cov_ok   = &mask_now;
  assign cov_full = &mask_q;
`else
  assign cov_ok   = 1'b1;
  assign cov_full = 1'b1;
`endif

  // Next-state and next-output logic for LOAD -> SERVE -> DONE.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    ld_ready_d = ld_ready_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    cycles_d   = cycles_q;

    unique case (state_q)
      LOAD: begin
        if (ld_fire) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d    = SERVE;
            ld_ready_d = 1'b0;
            busy_d     = 1'b1;
            cycles_d   = '0;
          end
        end
      end
      SERVE: begin
        cycles_d = cycles_inc;
        // Valid is checked first so a result on the last allowed cycle still counts.
        if (Valid) begin
          pass_d  = result_ok && cov_ok;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (cycles_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Frozen until reset.
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (RST) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      ld_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      cycles_q   <= cycles_d;
    end
  end

  assign ld_ready = ld_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign cycles   = cycles_q;

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
Responder side of the JAM cost-table interface. It holds the 8x8 worker/job cost table, which is loaded over a valid/ready stream. It answers the JAM requester's W/J address with Cost in the same cycle. It then captures the requester's MinCost/MatchCount when Valid asserts and checks them against expected values, with a cycle count and a timeout watchdog. System integration: the JAM requester is held in reset until busy rises.

Parameters:
COST_W, 7, width of one cost entry
RES_W, 10, MinCost width
CNT_W, 17, cycle-counter width
TIMEOUT, 50000, SERVE cycles allowed before Valid is required

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous, active-high reset
ld_valid  in  1  load word present
ld_ready  out  1  server accepts load word
ld_data  in  COST_W  cost word, row-major order (W outer, J inner)
W  in  3  requester worker index
J  in  3  requester job index
Cost  out  COST_W  table[W][J]
MinCost  in  RES_W  requester result
MatchCount  in  4  requester result
Valid  in  1  requester result valid
exp_min_cost  in  RES_W  expected MinCost, static during SERVE
exp_match_count  in  4  expected MatchCount
busy  out  1  in SERVE
done  out  1  check finished
pass  out  1  result matched
timeout  out  1  watchdog fired
cycles  out  CNT_W  SERVE cycles elapsed

Behaviour:
- States: LOAD -> SERVE -> DONE. DONE holds until RST.
- Reset values: state=LOAD, idx=0, ld_ready=1, busy=0, done=0, pass=0, timeout=0, cycles=0, Cost=0. Table storage is not reset.
- LOAD:
  - ld_ready=1.
  - On a posedge with ld_valid&ld_ready: table[idx[5:3]][idx[2:0]] <= ld_data, idx++.
  - Gaps in ld_valid are allowed.
  - Acceptance with idx==63 moves to SERVE next cycle and clears cycles.
  - Valid, W and J are ignored in LOAD.
- SERVE:
  - ld_ready=0, busy=1.
  - Cost = table[W][J], combinational, zero latency, so the requester may sample on either clock edge.
  - cycles increments every cycle.
  - Valid=1 at a posedge: capture MinCost and MatchCount, set pass = (MinCost==exp_min_cost && MatchCount==exp_match_count), done<=1, go to DONE.
  - If cycles==TIMEOUT-1 with Valid=0: timeout<=1, done<=1, pass<=0, go to DONE.
  - Valid arriving on the timeout cycle itself: Valid wins.
- DONE:
  - busy=0, Cost=0.
  - Outputs are frozen; cycles holds its final value.
  - Further Valid pulses are ignored.
- Outside SERVE, Cost is forced to 0, so there is no X from the uninitialised table.
- RST mid-LOAD or mid-SERVE: returns to LOAD with idx=0 and all outputs at reset values. A partial load is discarded, and the full 64 words must be reloaded.
- cycles saturates at all-ones and never wraps.

Optional Feature:
JAM_READ_COVERAGE_EN
- Defined: a 64-bit mask sets bit {W,J} on every SERVE cycle. pass additionally requires mask==all-ones at capture. An extra output cov_full (1 bit) reflects the mask being all-ones.
- Undefined: no mask is built, cov_full is tied to 1, and pass depends on the result compare only.

Decomposition:
- Package jam_pkg holds:
  - constants N_WORKER=8, TABLE_DEPTH=64, IDX_W=6, COST_W
  - state enum {LOAD, SERVE, DONE}
- Sub-module jam_cost_table: 64xCOST_W register array, one synchronous write port, one combinational read port addressed by {W,J}.

Test Plan:
1. Load table[w][j]=w*8+j, then drive W=3,J=5 in SERVE -> Cost=29. During LOAD -> Cost=0, ld_ready=1, busy=0.
2. Load 1 on the diagonal and 10 elsewhere, exp=8/1, drive Valid with MinCost=8, MatchCount=1 after 20 SERVE cycles -> done=1, pass=1, cycles=20, busy=0.
3. Same table, drive MinCost=9, MatchCount=1 -> done=1, pass=0, timeout=0.
4. TIMEOUT=100 and Valid never asserted -> on cycle 100 of SERVE, timeout=1, done=1, pass=0.
5. Load with random ld_valid gaps, plus ld_valid held high during SERVE -> table matches the 64 accepted words, and no write occurs in SERVE (ld_ready=0).
6. Assert RST at SERVE cycle 10 -> next cycle state=LOAD, idx=0, all outputs at reset values. After a full reload, scenario 2 passes.
